// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: frame-level SPI (mode 0) slave controller for the MD5 core register bank.
// Oversamples sclk/sel/mosi in the clk domain, assembles MSB-first bytes, decodes a
// command/address header and sequences register-bank writes and reads. Owns miso.
// Ports:
//   clk, reset                    system clock, asynchronous active-low reset
//   sclk, sel, mosi               SPI pins (asynchronous to clk)
//   miso                          SPI data out
//   wr_en, wr_addr, wr_data       one-cycle register write strobe with address/data
//   rd_en, rd_addr, rd_data       one-cycle read request; rd_data valid the following cycle
//   status                        byte returned by the status command
//   busy                          frame in progress (synchronized sel)
//   frame_err                     one-cycle pulse on bad command or partial byte at sel drop
module spi_frame_ctrl #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              sel,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic [7:0]        status,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [BYTE_W-1:0] CMD_WR   = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_RD   = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_STAT = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_STAT, S_IGNORE
  } state_t;

  state_t state, state_d;

  logic [2:0] sclk_sync, sel_sync;
  logic [1:0] mosi_sync;

  logic              is_rd, is_rd_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [BYTE_W-1:0] rx, rx_d;
  logic [BYTE_W-1:0] tx, tx_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              rd_pend;
  logic              miso_d, wr_en_d, rd_en_d, busy_d, frame_err_d;
  logic [ADDR_W-1:0] wr_addr_d, rd_addr_d;
  logic [BYTE_W-1:0] wr_data_d;

  logic              sclk_rise_c, sclk_fall_c, sel_rise_c, sel_fall_c;
  logic              byte_done_c;
  logic [BYTE_W-1:0] rx_byte_c;

  // Two-flop synchronizers; the third flop on sclk/sel feeds edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      sel_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      sel_sync  <= {sel_sync[1:0], sel};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_rise_c = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall_c = ~sclk_sync[1] & sclk_sync[2];
  assign sel_rise_c  = sel_sync[1] & ~sel_sync[2];
  assign sel_fall_c  = ~sel_sync[1] & sel_sync[2];

  // The byte completes in the cycle its 8th rising edge is seen, so strobes land one clk later
  assign rx_byte_c   = {rx[BYTE_W-2:0], mosi_sync[1]};
  assign byte_done_c = (state != S_IDLE) && sclk_rise_c && (cnt == CNT_W'(7));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      is_rd     <= 1'b0;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      addr      <= '0;
      rd_pend   <= 1'b0;
      miso      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      is_rd     <= is_rd_d;
      cnt       <= cnt_d;
      rx        <= rx_d;
      tx        <= tx_d;
      addr      <= addr_d;
      rd_pend   <= rd_en;
      miso      <= miso_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      rd_en     <= rd_en_d;
      rd_addr   <= rd_addr_d;
      busy      <= busy_d;
      frame_err <= frame_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    is_rd_d     = is_rd;
    cnt_d       = cnt;
    rx_d        = rx;
    tx_d        = tx;
    addr_d      = addr;
    miso_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr;
    frame_err_d = 1'b0;

    if ((state != S_IDLE) && sclk_rise_c) begin
      rx_d  = rx_byte_c;
      cnt_d = cnt + CNT_W'(1);
    end

    // miso presents the current tx MSB on each falling edge, then tx shifts
    if ((state == S_RDATA) || (state == S_STAT)) begin
      miso_d = miso;
      if (sclk_fall_c) begin
        miso_d = tx[BYTE_W-1];
        tx_d   = {tx[BYTE_W-2:0], 1'b0};
      end
    end

    // Bank answers one cycle after rd_en; load before the next falling edge
    if ((state == S_RDATA) && rd_pend) begin
      tx_d   = rd_data;
      miso_d = rd_data[BYTE_W-1];
    end

    case (state)
      S_IDLE: begin
        if (sel_rise_c) state_d = S_CMD;
      end
      S_CMD: begin
        if (byte_done_c) begin
          case (rx_byte_c)
            CMD_WR: begin
              state_d = S_ADDR;
              is_rd_d = 1'b0;
            end
            CMD_RD: begin
              state_d = S_ADDR;
              is_rd_d = 1'b1;
            end
            CMD_STAT: begin
              state_d = S_STAT;
              tx_d    = status;
            end
            default: begin
              state_d     = S_IGNORE;
              frame_err_d = 1'b1;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (byte_done_c) begin
          addr_d = rx_byte_c[ADDR_W-1:0];
          if (is_rd) begin
            state_d   = S_RDATA;
            rd_en_d   = 1'b1;
            rd_addr_d = rx_byte_c[ADDR_W-1:0];
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (byte_done_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr;
          wr_data_d = rx_byte_c;
          addr_d    = addr + ADDR_W'(1);
        end
      end
      S_RDATA: begin
        // Prefetch the next address while the current byte shifts out
        if (byte_done_c) begin
          addr_d    = addr + ADDR_W'(1);
          rd_en_d   = 1'b1;
          rd_addr_d = addr + ADDR_W'(1);
        end
      end
      S_STAT: begin
        if (byte_done_c) tx_d = status;
      end
      S_IGNORE: begin
      end
      default: state_d = S_IDLE;
    endcase

    // A byte completing in the same cycle as sel drop is not a partial byte
    if ((state != S_IDLE) && sel_fall_c) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rx_d    = '0;
      miso_d  = 1'b0;
      if ((cnt != '0) && !byte_done_c) frame_err_d = 1'b1;
    end

    busy_d = sel_sync[1] && (state_d != S_IDLE);
  end

endmodule
